rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Two-port (fetch/load) arbiter in front of a single-beat ROM read port.
// One transaction in flight: grant, issue to the ROM with timeout, one-cycle response.
module rom_port_arbiter #(
  parameter int ROM_BYTES = 1024,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,

  input  logic        ls_req_valid,
  input  logic [31:0] ls_req_addr,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        ls_rsp_err,

  output logic        rom_tx_valid,
  output logic [31:0] rom_addr,
  input  logic        rom_tx_ready,
  input  logic [31:0] rom_data
);

  // state | meaning
  // IDLE  | waiting for a request; grants one port per cycle
  // ISSUE | ROM read outstanding; first cycle ignores rom_tx_ready
  // RESP  | one-cycle response pulse to the granted port
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0]   ADDR_MAX  = 32'(ROM_BYTES - 4);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   addr_q;
  logic          port_q;       // 0 = fetch, 1 = load
  logic          last_grant;   // 0 = fetch, 1 = load
  logic [CW-1:0] wait_cnt;

  logic [31:0]   if_data_q;
  logic [31:0]   ls_data_q;
  logic          if_err_q;
  logic          ls_err_q;

  logic          grant_any;
  logic          grant_ls;
  logic [31:0]   grant_addr;
  logic          grant_err;
  logic          rom_ok;
  logic          rom_to;
  logic          fin_valid;
  logic          fin_port;
  logic [31:0]   fin_data;
  logic          fin_err;

  // On a tie the port not granted last wins; a lone requester always wins.
  always_comb begin
    grant_any  = if_req_valid | ls_req_valid;
    grant_ls   = ls_req_valid & (~if_req_valid | ~last_grant);
    grant_addr = grant_ls ? ls_req_addr : if_req_addr;
    grant_err  = (grant_addr[1:0] != 2'b00) || (grant_addr > ADDR_MAX);
  end

  always_comb begin
    rom_ok = (state == S_ISSUE) && (wait_cnt != CNT_ZERO) && rom_tx_ready;
    rom_to = (state == S_ISSUE) && !rom_ok && ((wait_cnt + CNT_ONE) == TIMEOUT_C);
  end

  // Completion event: loads the granted port's response registers.
  always_comb begin
    fin_valid = 1'b0;
    fin_port  = port_q;
    fin_data  = 32'd0;
    fin_err   = 1'b0;
    if (state == S_IDLE && grant_any && grant_err) begin
      fin_valid = 1'b1;
      fin_port  = grant_ls;
      fin_err   = 1'b1;
    end else if (rom_ok) begin
      fin_valid = 1'b1;
      fin_data  = rom_data;
    end else if (rom_to) begin
      fin_valid = 1'b1;
      fin_err   = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_any) state_nxt = grant_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (rom_ok || rom_to) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= 32'd0;
      port_q     <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_any) begin
        addr_q     <= grant_addr;
        port_q     <= grant_ls;
        last_grant <= grant_ls;
        wait_cnt   <= CNT_ZERO;
      end else if (state == S_ISSUE) begin
        wait_cnt <= wait_cnt + CNT_ONE;
      end
    end
  end

  // Response data/err hold until the same port's next response.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_data_q <= 32'd0;
      ls_data_q <= 32'd0;
      if_err_q  <= 1'b0;
      ls_err_q  <= 1'b0;
    end else if (fin_valid) begin
      if (fin_port) begin
        ls_data_q <= fin_data;
        ls_err_q  <= fin_err;
      end else begin
        if_data_q <= fin_data;
        if_err_q  <= fin_err;
      end
    end
  end

  always_comb begin
    if_req_ready = (state == S_IDLE) && grant_any && !grant_ls;
    ls_req_ready = (state == S_IDLE) && grant_ls;
    if_rsp_valid = (state == S_RESP) && !port_q;
    ls_rsp_valid = (state == S_RESP) && port_q;
    if_rsp_data  = if_data_q;
    ls_rsp_data  = ls_data_q;
    if_rsp_err   = if_err_q;
    ls_rsp_err   = ls_err_q;
    rom_tx_valid = (state == S_ISSUE);
    rom_addr     = (state == S_ISSUE) ? addr_q : 32'd0;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized self-checking bench for rom_port_arbiter against a transaction-level model.
module tb_rom_port_arbiter;
  localparam int ROM_BYTES = 1024;
  localparam int TIMEOUT   = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0][31:0] req_addr  = '0;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_err;
  logic [1:0][31:0] rsp_data;
  logic             rom_tx_valid;
  logic             rom_tx_ready;
  logic [31:0]      rom_addr;
  logic [31:0]      rom_data;

  logic [31:0] mem [256];
  int  issue_cnt = 0;
  int  rom_delay = 0;
  bit  rom_stuck = 1'b0;
  bit  rom_force_ready = 1'b0;
  int  tests = 0;
  int  fails = 0;

  rom_port_arbiter #(.ROM_BYTES(ROM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(req_valid[0]), .if_req_addr(req_addr[0]), .if_req_ready(req_ready[0]),
    .if_rsp_valid(rsp_valid[0]), .if_rsp_data(rsp_data[0]), .if_rsp_err(rsp_err[0]),
    .ls_req_valid(req_valid[1]), .ls_req_addr(req_addr[1]), .ls_req_ready(req_ready[1]),
    .ls_rsp_valid(rsp_valid[1]), .ls_rsp_data(rsp_data[1]), .ls_rsp_err(rsp_err[1]),
    .rom_tx_valid(rom_tx_valid), .rom_addr(rom_addr),
    .rom_tx_ready(rom_tx_ready), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM model: ready once the request has been visible for rom_delay prior cycles.
  always @(posedge clk) issue_cnt <= rom_tx_valid ? issue_cnt + 1 : 0;
  assign rom_tx_ready = rom_force_ready | (!rom_stuck && rom_tx_valid && issue_cnt >= rom_delay);
  assign rom_data = mem[rom_addr[9:2]];

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(ROM_BYTES - 4));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, ROM_BYTES / 4 - 1)) << 2;
    return a;
  endfunction

  function automatic logic [1:0] port_mask(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 2'b00; rom_force_ready = 1'b0; rom_stuck = 1'b0; rom_delay = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One isolated request; expectations derived from the timing rules.
  task automatic run_req(input int p, input logic [31:0] a, input int d, input bit stuck,
                         input string tag);
    bit err, got, addr_bad;
    int issue, lat, lat_exp, rom_cyc;
    logic [31:0] exp_d;
    err = addr_err(a);
    issue = 0;
    if (!err) begin
      if (stuck || d + 1 > TIMEOUT) begin issue = TIMEOUT; err = 1'b1; end
      else issue = (d + 1 < 2) ? 2 : d + 1;
    end
    lat_exp = addr_err(a) ? 1 : issue + 1;
    exp_d = err ? 32'd0 : mem[a[9:2]];
    rom_delay = d; rom_stuck = stuck;
    @(posedge clk); #1;
    req_valid[p] = 1'b1; req_addr[p] = a;
    @(negedge clk);
    tests++;
    if (req_ready !== port_mask(p)) begin
      fails++; $display("FAIL %s grant: got %b want %b", tag, req_ready, port_mask(p));
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0; req_addr[p] = $urandom;
    got = 0; rom_cyc = 0; addr_bad = 0; lat = 0;
    for (int k = 1; k <= TIMEOUT + 6 && !got; k++) begin
      @(negedge clk);
      if (rom_tx_valid) begin
        rom_cyc++;
        if (rom_addr !== a) addr_bad = 1'b1;
      end
      if (rsp_valid !== 2'b00) begin got = 1'b1; lat = k; end
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL %s response: got none want rsp_valid within %0d cycles", tag, TIMEOUT + 6);
      return;
    end
    tests++;
    if (lat != lat_exp) begin fails++; $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp); end
    tests++;
    if (rsp_valid !== port_mask(p)) begin
      fails++; $display("FAIL %s rsp_valid: got %b want %b", tag, rsp_valid, port_mask(p));
    end
    tests++;
    if (rsp_data[p] !== exp_d) begin
      fails++; $display("FAIL %s data: got %h want %h", tag, rsp_data[p], exp_d);
    end
    tests++;
    if (rsp_err[p] !== err) begin fails++; $display("FAIL %s err: got %b want %b", tag, rsp_err[p], err); end
    tests++;
    if (rom_cyc != issue || addr_bad) begin
      fails++; $display("FAIL %s rom_tx: got %0d cycles bad_addr=%0d want %0d cycles", tag, rom_cyc, addr_bad, issue);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b00 || rsp_data[p] !== exp_d || rsp_err[p] !== err) begin
      fails++; $display("FAIL %s hold: got valid=%b data=%h err=%b want valid=00 data=%h err=%b",
                        tag, rsp_valid, rsp_data[p], rsp_err[p], exp_d, err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 || rsp_data !== '0 ||
        rom_tx_valid !== 1'b0 || rom_addr !== 32'd0) begin
      fails++;
      $display("FAIL %s outputs: got rdy=%b rv=%b re=%b d0=%h d1=%h tv=%b ra=%h want all 0",
               tag, req_ready, rsp_valid, rsp_err, rsp_data[0], rsp_data[1], rom_tx_valid, rom_addr);
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    check_all_zero("reset");
  endtask

  task automatic test_single_fetch;
    mem[4] = 32'hDEADBEEF;
    run_req(0, 32'h10, 0, 1'b0, "single_fetch");
    run_req(1, 32'h3FC, 0, 1'b0, "last_word_ls");
  endtask

  task automatic test_round_robin;
    int last, exp_p, cyc, prev_g, k;
    bit found;
    logic [31:0] ga;
    do_reset();
    last = 1;
    req_addr[0] = rand_addr(); req_addr[1] = rand_addr();
    req_valid = 2'b11;
    cyc = 0; prev_g = -1;
    for (int t = 0; t < 3; t++) begin
      found = 0;
      for (k = 0; k < 10 && !found; k++) begin
        @(negedge clk); cyc++;
        if (req_ready !== 2'b00) found = 1'b1;
      end
      tests++;
      if (!found) begin fails++; $display("FAIL rr_grant%0d: got no grant want one", t); break; end
      exp_p = 1 - last;
      tests++;
      if (req_ready !== port_mask(exp_p)) begin
        fails++; $display("FAIL rr_order%0d: got %b want %b", t, req_ready, port_mask(exp_p));
      end
      if (prev_g >= 0) begin
        tests++;
        if (cyc - prev_g != 4) begin fails++; $display("FAIL rr_gap%0d: got %0d want 4", t, cyc - prev_g); end
      end
      prev_g = cyc; last = exp_p;
      ga = req_addr[exp_p];
      @(posedge clk); #1;
      req_addr[exp_p] = rand_addr();
      found = 0;
      for (k = 0; k < 10 && !found; k++) begin
        @(negedge clk); cyc++;
        if (rsp_valid !== 2'b00) found = 1'b1;
      end
      tests++;
      if (!found || cyc - prev_g != 3 || rsp_valid !== port_mask(exp_p) ||
          rsp_data[exp_p] !== mem[ga[9:2]] || rsp_err[exp_p] !== 1'b0) begin
        fails++;
        $display("FAIL rr_rsp%0d: got lat=%0d valid=%b data=%h err=%b want lat=3 valid=%b data=%h err=0",
                 t, cyc - prev_g, rsp_valid, rsp_data[exp_p], rsp_err[exp_p], port_mask(exp_p), mem[ga[9:2]]);
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_errors;
    logic [31:0] bad [4];
    bad[0] = 32'h6; bad[1] = 32'h3FE; bad[2] = 32'h400; bad[3] = 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) run_req(i % 2, bad[i], 0, 1'b0, "addr_err");
  endtask

  task automatic test_timeout;
    run_req(0, 32'h20, 0, 1'b1, "timeout");
    run_req(1, 32'h24, 0, 1'b0, "after_timeout");
    run_req(0, 32'h28, TIMEOUT - 1, 1'b0, "ready_last_cycle");
  endtask

  task automatic test_reset_mid;
    bit bad_pulse;
    rom_delay = 8; rom_stuck = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = 32'h40;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rom_force_ready = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    @(posedge clk); #1;
    rom_force_ready = 1'b0;
    bad_pulse = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || rom_tx_valid !== 1'b0) bad_pulse = 1'b1;
    end
    tests++;
    if (bad_pulse) begin fails++; $display("FAIL reset_mid_quiet: got activity want none"); end
    run_req(0, 32'h10, 0, 1'b0, "post_reset");
  endtask

  task automatic test_random;
    int p, d, r;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 7)       a = rand_addr();
      else if (r == 7) a = rand_addr() | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(ROM_BYTES) + (32'($urandom_range(0, 63)) << 2);
      else             a = $urandom;
      d = $urandom_range(0, 17);
      run_req(p, a, d, (d == 17), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
